// File: rtl/dadda_pkg.sv
// Shared definitions for the iterative 16x16 multiplier built on the 8x8 Dadda core.
package dadda_pkg;

  localparam int DADDA_IN_W = 8;
  localparam int ITER_IN_W  = 16;
  localparam int ITER_OUT_W = 32;
  localparam int NUM_STEPS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Left shift applied to the byte product of a given step: lo*lo=0, cross terms=8, hi*hi=16.
  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [4:0] sh;
    case (step)
      2'd0:    sh = 5'd0;
      2'd1:    sh = 5'd8;
      2'd2:    sh = 5'd8;
      default: sh = 5'd16;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/dadda_8.sv
// Combinational 8x8 unsigned multiplier: partial-product array reduced with 3:2
// carry-save compressors, then one final carry-propagate add.
module dadda_8
  import dadda_pkg::*;
(
  input  logic [DADDA_IN_W-1:0]   in1,
  input  logic [DADDA_IN_W-1:0]   in2,
  output logic [2*DADDA_IN_W-1:0] prod
);

  localparam int PW = 2 * DADDA_IN_W;

  logic [PW-1:0] pp [DADDA_IN_W];
  logic [PW-1:0] sum_v;
  logic [PW-1:0] carry_v;
  logic [PW-1:0] maj_v;

  // Build the shifted partial products, one per multiplier bit.
  always_comb begin
    for (int i = 0; i < DADDA_IN_W; i++) begin
      pp[i] = in2[i] ? (PW'(in1) << i) : '0;
    end
  end

  // Fold partial products into a sum/carry pair; carries beyond bit 15 can be dropped
  // because the true product always fits in 16 bits.
  always_comb begin
    sum_v   = pp[0];
    carry_v = '0;
    maj_v   = '0;
    for (int i = 1; i < DADDA_IN_W; i++) begin
      maj_v   = (sum_v & carry_v) | (sum_v & pp[i]) | (carry_v & pp[i]);
      sum_v   = sum_v ^ carry_v ^ pp[i];
      carry_v = {maj_v[PW-2:0], 1'b0};
    end
    prod = sum_v + carry_v;
  end

endmodule

// File: rtl/dadda_16_iter.sv
// Iterative 16x16 -> 32 unsigned multiplier. One dadda_8 core is time-shared over
// four cycles; byte products are shift-accumulated into a 32-bit register.
module dadda_16_iter
  import dadda_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ITER_IN_W-1:0]  in1,
  input  logic [ITER_IN_W-1:0]  in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_OUT_W-1:0] prod
);

  state_e                  state_q, state_d;
  logic [1:0]              step_q, step_d;
  logic [ITER_IN_W-1:0]    a_q, a_d;
  logic [ITER_IN_W-1:0]    b_q, b_d;
  logic [ITER_OUT_W-1:0]   acc_q, acc_d;

  logic [DADDA_IN_W-1:0]   core_a;
  logic [DADDA_IN_W-1:0]   core_b;
  logic [2*DADDA_IN_W-1:0] core_p;
  logic [ITER_OUT_W-1:0]   partial;

  // Step selects the byte pair: bit 1 picks the high byte of A, bit 0 the high byte of B.
  always_comb begin
    core_a  = step_q[1] ? a_q[15:8] : a_q[7:0];
    core_b  = step_q[0] ? b_q[15:8] : b_q[7:0];
    partial = {16'b0, core_p} << step_shift(step_q);
  end

  dadda_8 u_core (
    .in1  (core_a),
    .in2  (core_b),
    .prod (core_p)
  );

  // Handshake outputs; in_ready is masked by rst so it stays low while reset is held.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    prod      = acc_q;
  end

  // Next-state, operand capture and shift-accumulate.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no branch infers a latch.
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in1;
          b_d     = in2;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == 2'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in progress and discards the partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_dadda_16_iter.sv
// Scoreboard bench for dadda_16_iter: stimulus pushes expected products, a
// negedge monitor pops and compares on every output handshake.
module tb_dadda_16_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  dadda_16_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Offer an operand pair and wait (bounded) for acceptance; optionally record the expected product.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] expv, input bit push);
    int cnt = 0;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt == 50) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(expv);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  // Monitor: compare on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        check("result", prod, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;

    // Reset values while rst is held.
    cycles(2);
    check("rst_in_ready",  {31'b0, in_ready},  32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_prod",      prod,               32'd0);
    rst = 1'b0;
    cycles(1);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1 x 2 with latency: out_valid only after the fourth edge following accept.
    send(16'd1, 16'd2, 32'h0000_0002, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cycles(1);
      check($sformatf("lat_out_valid_e%0d", k), {31'b0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    drain();

    // Maximum operands: no wrap.
    send(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
    drain();

    // Back-to-back: next pair held on the bus, in_ready low through MUL and DONE.
    send(16'h8000, 16'h4000, 32'h2000_0000, 1'b1);
    in1      = 16'h1234;
    in2      = 16'h5678;
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycles(1);
      check($sformatf("b2b_in_ready_e%0d", k), {31'b0, in_ready}, 32'd0);
    end
    send(16'h1234, 16'h5678, 32'h0626_0060, 1'b1);
    drain();

    // Backpressure: 200 x 38 held in DONE while 7 x 9 is offered and must be ignored.
    out_ready = 1'b0;
    send(16'd200, 16'd38, 32'h0000_1DB0, 1'b1);
    cycles(4);
    in1      = 16'd7;
    in2      = 16'd9;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_prod",      prod,               32'h0000_1DB0);
      check("bp_in_ready",  {31'b0, in_ready},  32'd0);
      cycles(1);
    end
    out_ready = 1'b1;
    send(16'd7, 16'd9, 32'h0000_003F, 1'b1);
    drain();

    // Reset during MUL step 2: immediate abort, no result.
    send(16'h1111, 16'h2222, 32'd0, 1'b0);
    cycles(2);
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_prod",      prod,               32'd0);
    check("abort_in_ready",  {31'b0, in_ready},  32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(1);
    check("abort_post_in_ready", {31'b0, in_ready}, 32'd1);
    cycles(6);
    check("abort_no_output", {31'b0, out_valid}, 32'd0);
    send(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b1);
    drain();
    cycles(2);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
